// File: rtl/pp_alu_sched.sv
// Round-robin scheduler that shares one fixed-point ALU among NumReq requesters,
// with burst-locked grants, in-order tagged responses and a flush/drain path.
module pp_alu_sched #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned NumSize  = 32,
  parameter int unsigned CmdW     = 4,
  parameter int unsigned BurstLen = 8,
  parameter int unsigned AluLat   = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NumReq-1:0]         req_valid_i,
  output logic [NumReq-1:0]         req_ready_o,
  input  logic [NumReq*CmdW-1:0]    req_cmd_i,
  input  logic [NumReq*NumSize-1:0] req_in1_i,
  input  logic [NumReq*NumSize-1:0] req_in2_i,
  output logic [CmdW-1:0]           alu_cmd_o,
  output logic [NumSize-1:0]        alu_in1_o,
  output logic [NumSize-1:0]        alu_in2_o,
  input  logic [NumSize-1:0]        alu_out1_i,
  output logic [NumReq-1:0]         rsp_valid_o,
  output logic [NumSize-1:0]        rsp_data_o,
  output logic                      rsp_err_o,
  input  logic                      flush_i,
  output logic                      flush_done_o,
  output logic                      busy_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned TagW = NumReq + 3;
  localparam logic [CmdW-1:0] CmdNoop = '0;
  localparam logic [CmdW-1:0] CmdAdd  = CmdW'(1);

  typedef enum logic [1:0] {StIdle, StGrant, StDrain} state_e;

  state_e             state_q;
  logic [IdxW-1:0]    owner_q;
  logic [IdxW-1:0]    rr_ptr_q;
  logic [7:0]         burst_cnt_q;
  logic               flush_done_q;
  logic [CmdW-1:0]    alu_cmd_q;
  logic [NumSize-1:0] alu_in1_q;
  logic [NumSize-1:0] alu_in2_q;
  logic [NumReq-1:0]  rsp_valid_q;
  logic [NumSize-1:0] rsp_data_q;
  logic               rsp_err_q;
  // Tag layout: {valid, err, noop, owner one-hot}
  logic [TagW-1:0]    tag_q [AluLat+1];

  logic [IdxW-1:0]    pick;
  logic [IdxW-1:0]    owner_nxt;
  logic               any_valid;
  logic               hs;
  logic               burst_end;
  logic [8:0]         burst_inc;
  logic               tags_busy;
  logic [CmdW-1:0]    own_cmd;
  logic [NumSize-1:0] own_in1;
  logic [NumSize-1:0] own_in2;
  logic               own_err;
  logic               own_noop;

  // First valid requester at or after rr_ptr_q, with wrap.
  always_comb begin
    logic             found;
    logic [IdxW-1:0]  cand;
    int unsigned      idx;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx  = (32'(rr_ptr_q) + k) % NumReq;
      cand = IdxW'(idx);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int unsigned i = 0; i <= AluLat; i++) begin
      tags_busy = tags_busy | tag_q[i][TagW-1];
    end
  end

  assign any_valid   = |req_valid_i;
  assign own_cmd     = req_cmd_i[owner_q*CmdW +: CmdW];
  assign own_in1     = req_in1_i[owner_q*NumSize +: NumSize];
  assign own_in2     = req_in2_i[owner_q*NumSize +: NumSize];
  assign own_noop    = (own_cmd == CmdNoop);
  assign own_err     = !own_noop && (own_cmd != CmdAdd);
  assign req_ready_o = (state_q == StGrant && !flush_i) ? (NumReq'(1) << owner_q) : '0;
  assign hs          = (state_q == StGrant) && !flush_i && req_valid_i[owner_q];
  assign burst_inc   = {1'b0, burst_cnt_q} + 9'd1;
  assign burst_end   = (burst_inc == 9'(BurstLen));
  assign owner_nxt   = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      burst_cnt_q  <= '0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (flush_i) begin
            state_q <= StDrain;
          end else if (any_valid) begin
            state_q <= StGrant;
            owner_q <= pick;
          end
        end
        StGrant: begin
          if (flush_i) begin
            state_q     <= StDrain;
            burst_cnt_q <= '0;
          end else if (hs && !burst_end) begin
            burst_cnt_q <= burst_inc[7:0];
          end else begin
            // Burst exhausted, or owner dropped valid without a handshake.
            state_q     <= StIdle;
            rr_ptr_q    <= owner_nxt;
            burst_cnt_q <= '0;
          end
        end
        StDrain: begin
          if (!tags_busy) begin
            state_q      <= StIdle;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Illegal and NOOP opcodes reach the ALU as NOOP; operands hold when idle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      alu_cmd_q <= CmdNoop;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
    end else begin
      alu_cmd_q <= (hs && own_cmd == CmdAdd) ? CmdAdd : CmdNoop;
      if (hs) begin
        alu_in1_q <= own_in1;
        alu_in2_q <= own_in2;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i <= AluLat; i++) begin
        tag_q[i] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      tag_q[0] <= {hs, own_err, own_noop, req_ready_o};
      for (int unsigned i = 1; i <= AluLat; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (tag_q[AluLat][TagW-1]) begin
        rsp_valid_q <= tag_q[AluLat][NumReq-1:0];
        rsp_err_q   <= tag_q[AluLat][TagW-2];
        rsp_data_q  <= (tag_q[AluLat][TagW-2] || tag_q[AluLat][TagW-3]) ? '0 : alu_out1_i;
      end else begin
        rsp_valid_q <= '0;
        rsp_err_q   <= 1'b0;
        rsp_data_q  <= '0;
      end
    end
  end

  assign alu_cmd_o    = alu_cmd_q;
  assign alu_in1_o    = alu_in1_q;
  assign alu_in2_o    = alu_in2_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign flush_done_o = flush_done_q;
  assign busy_o       = (state_q != StIdle) || tags_busy;

endmodule

// File: tb/tb_pp_alu_sched.sv
// Self-checking bench for pp_alu_sched: directed scenarios plus a randomized run,
// with a scoreboard predicting every response from the accepted beats.
module tb_pp_alu_sched;
  localparam int NR = 4;
  localparam int W  = 32;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*CW-1:0]  req_cmd = '0;
  logic [NR*W-1:0]   req_in1 = '0;
  logic [NR*W-1:0]   req_in2 = '0;
  logic [CW-1:0]     alu_cmd;
  logic [W-1:0]      alu_in1;
  logic [W-1:0]      alu_in2;
  logic [W-1:0]      alu_out1;
  logic [NR-1:0]     rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              flush = 1'b0;
  logic              flush_done;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [NR-1:0] vld;
    logic [W-1:0]  data;
    logic          err;
    int            cyc;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t rsp_log[$];

  pp_alu_sched dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_cmd_i    (req_cmd),
    .req_in1_i    (req_in1),
    .req_in2_i    (req_in2),
    .alu_cmd_o    (alu_cmd),
    .alu_in1_o    (alu_in1),
    .alu_in2_o    (alu_in2),
    .alu_out1_i   (alu_out1),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err),
    .flush_i      (flush),
    .flush_done_o (flush_done),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // One-cycle fixed-point adder standing in for the shared ALU.
  always @(posedge clk or posedge reset) begin
    if (reset) alu_out1 <= '0;
    else       alu_out1 <= (alu_cmd == 4'd1) ? alu_in1 + alu_in2 : '0;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Scoreboard: each accepted beat must come back once, in order, 3 cycles later.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
    end else begin
      checks++;
      if ($countones(req_ready) > 1) begin
        errors++;
        $display("FAIL ready_onehot got=%b required at most one bit", req_ready);
      end
      if (rsp_valid != '0) begin
        rsp_t r;
        r.vld = rsp_valid; r.data = rsp_data; r.err = rsp_err; r.cyc = cyc;
        rsp_log.push_back(r);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got vld=%b data=%h err=%b required none",
                   rsp_valid, rsp_data, rsp_err);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          if (r.vld !== e.vld || r.data !== e.data || r.err !== e.err || r.cyc != e.cyc) begin
            errors++;
            $display("FAIL rsp_scoreboard got vld=%b data=%h err=%b cyc=%0d required vld=%b data=%h err=%b cyc=%0d",
                     r.vld, r.data, r.err, r.cyc, e.vld, e.data, e.err, e.cyc);
          end
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          rsp_t e;
          logic [CW-1:0] c;
          logic [W-1:0]  a, b;
          c = req_cmd[i*CW +: CW];
          a = req_in1[i*W +: W];
          b = req_in2[i*W +: W];
          e.vld  = NR'(1 << i);
          e.data = (c == 4'd1) ? a + b : '0;
          e.err  = (c > 4'd1);
          e.cyc  = cyc + 3;
          exp_q.push_back(e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [CW-1:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_cmd[i*CW +: CW] = c;
    req_in1[i*W +: W]   = a;
    req_in2[i*W +: W]   = b;
  endtask

  // Call just after a rising edge; returns just after the handshake edge.
  task automatic send_beat(input int i, input logic [CW-1:0] c, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    int n;
    n = 0;
    set_req(i, c, a, b);
    req_valid[i] = 1'b1;
    @(negedge clk);
    while (!req_ready[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) begin
      checks++;
      errors++;
      $display("FAIL send_beat_timeout req=%0d ready=%b required bit set", i, req_ready);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (rsp_log.size() < n && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    if (rsp_log.size() < n) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout got=%0d responses required=%0d", rsp_log.size(), n);
    end
  endtask

  task automatic wait_quiet();
    int k;
    k = 0;
    req_valid = '0;
    flush = 1'b0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL quiet_timeout busy=%b required 0", busy);
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, flush_done, busy} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b rsp_valid=%b err=%b fd=%b busy=%b required all 0",
               req_ready, rsp_valid, rsp_err, flush_done, busy);
    end
    checks++;
    if ({alu_cmd, alu_in1, alu_in2, rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_data got alu_cmd=%h in1=%h in2=%h rsp_data=%h required 0",
               alu_cmd, alu_in1, alu_in2, rsp_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_release got busy=%b ready=%b required 0", busy, req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add();
    send_beat(0, 4'd1, 32'd3, 32'd4);
    @(negedge clk);
    checks++;
    if (alu_cmd !== 4'd1 || alu_in1 !== 32'd3 || alu_in2 !== 32'd4) begin
      errors++;
      $display("FAIL basic_issue got cmd=%h in1=%h in2=%h required 1 3 4", alu_cmd, alu_in1, alu_in2);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0) begin
      errors++;
      $display("FAIL basic_early got rsp_valid=%b required 0000", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'd7 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_rsp got vld=%b data=%h err=%b required 0001 7 0", rsp_valid, rsp_data, rsp_err);
    end
    wait_quiet();
  endtask

  task automatic test_wrap();
    rsp_log.delete();
    send_beat(1, 4'd1, 32'h7FFF_FFFF, 32'd1);
    send_beat(1, 4'd1, 32'hFFFF_FFFB, 32'd2);
    wait_log(2);
    if (rsp_log.size() >= 2) begin
      checks++;
      if (rsp_log[0].vld !== 4'b0010 || rsp_log[0].data !== 32'h8000_0000 || rsp_log[0].err !== 1'b0) begin
        errors++;
        $display("FAIL wrap_max got vld=%b data=%h err=%b required 0010 80000000 0",
                 rsp_log[0].vld, rsp_log[0].data, rsp_log[0].err);
      end
      checks++;
      if (rsp_log[1].vld !== 4'b0010 || rsp_log[1].data !== 32'hFFFF_FFFD || rsp_log[1].err !== 1'b0) begin
        errors++;
        $display("FAIL wrap_neg got vld=%b data=%h err=%b required 0010 fffffffd 0",
                 rsp_log[1].vld, rsp_log[1].data, rsp_log[1].err);
      end
    end
    wait_quiet();
  endtask

  task automatic test_illegal();
    rsp_log.delete();
    send_beat(3, 4'b0111, 32'h1234_5678, 32'h0000_00FF);
    @(negedge clk);
    checks++;
    if (alu_cmd !== 4'd0) begin
      errors++;
      $display("FAIL illegal_issue got alu_cmd=%h required 0", alu_cmd);
    end
    @(posedge clk); #1;
    send_beat(3, 4'd1, 32'd1, 32'd1);
    wait_log(2);
    if (rsp_log.size() >= 2) begin
      checks++;
      if (rsp_log[0].vld !== 4'b1000 || rsp_log[0].data !== '0 || rsp_log[0].err !== 1'b1) begin
        errors++;
        $display("FAIL illegal_rsp got vld=%b data=%h err=%b required 1000 0 1",
                 rsp_log[0].vld, rsp_log[0].data, rsp_log[0].err);
      end
      checks++;
      if (rsp_log[1].vld !== 4'b1000 || rsp_log[1].data !== 32'd2 || rsp_log[1].err !== 1'b0) begin
        errors++;
        $display("FAIL illegal_next got vld=%b data=%h err=%b required 1000 2 0",
                 rsp_log[1].vld, rsp_log[1].data, rsp_log[1].err);
      end
    end
    wait_quiet();
  endtask

  // From reset, req0 and req2 always valid: period of 18 cycles,
  // bubble + 8 grants to req0, bubble + 8 grants to req2.
  task automatic test_burst_rotation();
    logic [NR-1:0] want;
    int p;
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(0, 4'd1, $urandom, $urandom);
    set_req(2, 4'd1, $urandom, $urandom);
    req_valid = 4'b0101;
    for (int s = 0; s < 36; s++) begin
      @(negedge clk);
      p = s % 18;
      if (p == 0 || p == 9) want = 4'b0000;
      else if (p < 9)       want = 4'b0001;
      else                  want = 4'b0100;
      checks++;
      if (req_ready !== want) begin
        errors++;
        $display("FAIL burst_slot%0d got ready=%b required %b", s, req_ready, want);
      end
      @(posedge clk); #1;
      set_req(0, 4'd1, $urandom, $urandom);
      set_req(2, 4'd1, $urandom, $urandom);
    end
    wait_quiet();
  endtask

  task automatic test_flush();
    int hs_cnt;
    int pulses;
    int k;
    rsp_log.delete();
    hs_cnt = 0;
    pulses = 0;
    k = 0;
    set_req(1, 4'd1, $urandom, $urandom);
    req_valid[1] = 1'b1;
    while (hs_cnt < 3 && k < 40) begin
      @(negedge clk);
      if (req_ready[1]) hs_cnt++;
      @(posedge clk); #1;
      set_req(1, 4'd1, $urandom, $urandom);
      k++;
    end
    flush = 1'b1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL flush_ready got=%b required 0000", req_ready);
    end
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      if (flush_done) begin
        pulses++;
        flush = 1'b0;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL flush_done_pulses got=%0d required 1", pulses);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy got=%b required 0", busy);
    end
    checks++;
    if (rsp_log.size() != 3) begin
      errors++;
      $display("FAIL flush_rsp_count got=%0d required 3", rsp_log.size());
    end
    wait_quiet();
  endtask

  task automatic test_reset_inflight();
    send_beat(2, 4'd1, 32'd10, 32'd20);
    send_beat(2, 4'd1, 32'd30, 32'd40);
    reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, alu_cmd, alu_in1, alu_in2, flush_done, busy} !== '0) begin
      errors++;
      $display("FAIL reset_inflight got ready=%b vld=%b data=%h err=%b cmd=%h in1=%h in2=%h fd=%b busy=%b required 0",
               req_ready, rsp_valid, rsp_data, rsp_err, alu_cmd, alu_in1, alu_in2, flush_done, busy);
    end
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    rsp_log.delete();
    repeat (6) @(negedge clk);
    checks++;
    if (rsp_log.size() != 0) begin
      errors++;
      $display("FAIL reset_no_rsp got=%0d responses required 0", rsp_log.size());
    end
    @(posedge clk); #1;
    send_beat(2, 4'd1, 32'd2, 32'd2);
    wait_log(1);
    if (rsp_log.size() >= 1) begin
      checks++;
      if (rsp_log[0].vld !== 4'b0100 || rsp_log[0].data !== 32'd4 || rsp_log[0].err !== 1'b0) begin
        errors++;
        $display("FAIL reset_after got vld=%b data=%h err=%b required 0100 4 0",
                 rsp_log[0].vld, rsp_log[0].data, rsp_log[0].err);
      end
    end
    wait_quiet();
  endtask

  task automatic test_random();
    int r;
    logic [CW-1:0] c;
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < NR; i++) begin
        r = $urandom_range(0, 9);
        if (r < 7)       c = 4'd1;
        else if (r == 7) c = 4'd0;
        else             c = CW'($urandom_range(2, 15));
        set_req(i, c, $urandom, $urandom);
        req_valid[i] = ($urandom_range(0, 9) < 6);
      end
      @(posedge clk); #1;
    end
    wait_quiet();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain got=%0d outstanding required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_wrap();
    test_illegal();
    test_burst_rotation();
    test_flush();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
